// File: rtl/sram_bus_seq.sv
// Single-word request sequencer driving active-low SRAM strobes with setup/hold phasing.
// Optional write-verify read-back is enabled by defining SRAM_WR_VERIFY_EN.
module sram_bus_seq #(
    parameter int AW        = 7,
    parameter int DW        = 8,
    parameter int WE_CYCLES = 2,
    parameter int RD_WAIT   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_lb_n,
    output logic          sram_ub_n,
    output logic          err
);

    // state    | meaning
    // IDLE     | ready for a request, strobes released
    // W_SETUP  | chip selected, address/data settling before we_n falls
    // W_STROBE | we_n low for WE_CYCLES
    // W_HOLD   | we_n back high, address/data held while write commits
    // R_SETUP  | chip and output enable asserted
    // R_WAIT   | access time padding (RD_WAIT-1 cycles)
    // R_CAPT   | sample read data, pulse response
    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_WAIT, R_CAPT
    } state_t;

    localparam int MAX_WAIT = (WE_CYCLES > RD_WAIT) ? WE_CYCLES : RD_WAIT;
    localparam int CW       = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] WE_TC = CW'(WE_CYCLES - 1);
    localparam logic [CW-1:0] RD_TC = CW'((RD_WAIT > 1) ? RD_WAIT - 2 : 0);

    state_t        state;
    logic [CW-1:0] wait_cnt;

`ifdef SRAM_WR_VERIFY_EN
    logic vfy;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
`ifdef SRAM_WR_VERIFY_EN
            vfy        <= 1'b0;
            err        <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        sram_addr  <= req_addr;
                        sram_wdata <= req_wdata;
                        sram_ce_n  <= 1'b0;
                        sram_lb_n  <= 1'b0;
                        sram_ub_n  <= 1'b0;
                        if (req_we) begin
                            state <= W_SETUP;
                        end else begin
                            sram_oe_n <= 1'b0;
                            state     <= R_SETUP;
                        end
                    end
                end
                W_SETUP: begin
                    sram_we_n <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= W_STROBE;
                end
                W_STROBE: begin
                    if (wait_cnt == WE_TC) begin
                        sram_we_n <= 1'b1;
                        state     <= W_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                W_HOLD: begin
`ifdef SRAM_WR_VERIFY_EN
                    // we_n is already high here, so oe_n can fall without overlap
                    sram_oe_n <= 1'b0;
                    vfy       <= 1'b1;
                    state     <= R_SETUP;
`else
                    sram_ce_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
`endif
                end
                R_SETUP: begin
                    wait_cnt <= '0;
                    state    <= (RD_WAIT > 1) ? R_WAIT : R_CAPT;
                end
                R_WAIT: begin
                    if (wait_cnt == RD_TC) begin
                        state <= R_CAPT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                R_CAPT: begin
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
`ifdef SRAM_WR_VERIFY_EN
                    if (vfy) begin
                        vfy <= 1'b0;
                        if (sram_rdata != sram_wdata) begin
                            err <= 1'b1;
                        end
                    end else begin
                        rsp_data  <= sram_rdata;
                        rsp_valid <= 1'b1;
                    end
`else
                    rsp_data  <= sram_rdata;
                    rsp_valid <= 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_seq.sv
// Directed bench for sram_bus_seq with a behavioural SRAM that commits on rising we_n.
// With SRAM_WR_VERIFY_EN defined, address 0x3F has bit 7 stuck at 0.
module tb_sram_bus_seq;

    localparam int AW        = 7;
    localparam int DW        = 8;
    localparam int WE_CYCLES = 2;
    localparam int RD_WAIT   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sram_bus_seq #(.AW(AW), .DW(DW), .WE_CYCLES(WE_CYCLES), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // SRAM model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            wr_commits = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;

    always @(posedge sram_we_n) begin
        if (sram_ce_n === 1'b0) begin
`ifdef SRAM_WR_VERIFY_EN
            mem[sram_addr] = (sram_addr == 7'h3F) ? (sram_wdata & 8'h7F) : sram_wdata;
`else
            mem[sram_addr] = sram_wdata;
`endif
            wr_commits++;
            last_waddr = sram_addr;
            last_wdata = sram_wdata;
        end
    end

    assign sram_rdata = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0) ? mem[sram_addr] : '0;

    // Response capture and strobe-ordering monitor, sampled mid-cycle
    logic [DW-1:0] rsp_q [$];
    logic prev_ce_n = 1'b1;
    logic prev_we_n = 1'b1;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_q.push_back(rsp_data);
        if (rst === 1'b0) begin
            checks++;
            if (sram_oe_n === 1'b0 && sram_we_n === 1'b0) begin
                errors++;
                $display("FAIL oe_we_overlap oe_n=%b we_n=%b required not both 0", sram_oe_n, sram_we_n);
            end
            checks++;
            if (sram_we_n === 1'b0 && prev_we_n === 1'b1 && prev_ce_n !== 1'b0) begin
                errors++;
                $display("FAIL we_fall_without_ce prev_ce_n=%b required 0", prev_ce_n);
            end
        end
        prev_ce_n = sram_ce_n;
        prev_we_n = sram_we_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        ok = (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_strobes got %b required 11111",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
        end
        checks++;
        if (sram_addr !== 7'h00 || sram_wdata !== 8'h00 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs addr=%h wdata=%h rsp_data=%h required 0", sram_addr, sram_wdata, rsp_data);
        end
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags ready=%b rsp_valid=%b err=%b required 0", req_ready, rsp_valid, err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b required 1", req_ready);
        end
    endtask

    task automatic test_write();
        bit ok;
        int lowc;
        int base = wr_commits;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h05; req_wdata = 8'hA5;
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_accept_timeout ready=%b required 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b01100) begin
            errors++;
            $display("FAIL write_setup_strobes got %b required 01100",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
        end
        checks++;
        if (sram_addr !== 7'h05 || sram_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL write_setup_bus addr=%h data=%h required 05 a5", sram_addr, sram_wdata);
        end
        tick();
        lowc = (sram_we_n === 1'b0) ? 1 : 0;
        while (sram_we_n === 1'b0 && lowc < 10) begin
            tick();
            if (sram_we_n === 1'b0) lowc++;
        end
        checks++;
        if (lowc != WE_CYCLES) begin
            errors++;
            $display("FAIL write_we_width got %0d required %0d", lowc, WE_CYCLES);
        end
        checks++;
        if (sram_ce_n !== 1'b0 || sram_addr !== 7'h05 || sram_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL write_hold ce_n=%b addr=%h data=%h required 0 05 a5", sram_ce_n, sram_addr, sram_wdata);
        end
`ifndef SRAM_WR_VERIFY_EN
        tick();
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_release strobes=%b ready=%b required 11111 1",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, req_ready);
        end
`else
        wait_ready(ok);
`endif
        checks++;
        if (mem[5] !== 8'hA5 || wr_commits != base + 1) begin
            errors++;
            $display("FAIL write_commit mem5=%h commits=%0d required a5 %0d", mem[5], wr_commits - base, 1);
        end
    endtask

    task automatic test_read();
        bit ok;
        bit we_seen_low = 1'b0;
        int lat;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h05;
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL read_accept_timeout ready=%b required 1", req_ready); end
        rsp_q.delete();
        tick();
        req_valid = 1'b0;
        lat = 1;
        checks++;
        if (sram_ce_n !== 1'b0 || sram_oe_n !== 1'b0 || sram_we_n !== 1'b1) begin
            errors++;
            $display("FAIL read_setup ce_n=%b oe_n=%b we_n=%b required 0 0 1", sram_ce_n, sram_oe_n, sram_we_n);
        end
        while (rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
            if (sram_we_n !== 1'b1) we_seen_low = 1'b1;
        end
        checks++;
        if (lat != RD_WAIT + 2) begin
            errors++;
            $display("FAIL read_latency got %0d required %0d", lat, RD_WAIT + 2);
        end
        checks++;
        if (rsp_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_data got %h required a5", rsp_data);
        end
        checks++;
        if (we_seen_low) begin
            errors++;
            $display("FAIL read_we_n got 0 required 1");
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin
            errors++;
            $display("FAIL read_end rsp_valid=%b strobes=%b required 0 11111",
                     rsp_valid, {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int last = 0;
        int base = wr_commits;
        logic [DW-1:0] exp_d;
        req_valid = 1'b1; req_we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_addr = AW'(i); req_wdata = DW'(i + 1);
            wait_ready(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_write_timeout idx=%0d ready=%b required 1", i, req_ready); end
            tick();
`ifndef SRAM_WR_VERIFY_EN
            if (i > 0) begin
                checks++;
                if (cyc - last != WE_CYCLES + 3) begin
                    errors++;
                    $display("FAIL b2b_write_spacing idx=%0d got %0d required %0d", i, cyc - last, WE_CYCLES + 3);
                end
            end
`endif
            last = cyc;
        end
        req_valid = 1'b0;
        wait_ready(ok);
        checks++;
        if (wr_commits != base + 16) begin
            errors++;
            $display("FAIL b2b_write_count got %0d required 16", wr_commits - base);
        end
        for (int i = 0; i < 16; i++) begin
            exp_d = DW'(i + 1);
            checks++;
            if (mem[i] !== exp_d) begin
                errors++;
                $display("FAIL b2b_mem idx=%0d got %h required %h", i, mem[i], exp_d);
            end
        end
        rsp_q.delete();
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req_addr = AW'(i);
            wait_ready(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_read_timeout idx=%0d ready=%b required 1", i, req_ready); end
            tick();
            if (i > 0) begin
                checks++;
                if (cyc - last != RD_WAIT + 2) begin
                    errors++;
                    $display("FAIL b2b_read_spacing idx=%0d got %0d required %0d", i, cyc - last, RD_WAIT + 2);
                end
            end
            last = cyc;
        end
        req_valid = 1'b0;
        wait_ready(ok);
        tick();
        checks++;
        if (rsp_q.size() != 16) begin
            errors++;
            $display("FAIL b2b_rsp_count got %0d required 16", rsp_q.size());
        end
        for (int i = 0; i < 16 && i < rsp_q.size(); i++) begin
            exp_d = DW'(i + 1);
            checks++;
            if (rsp_q[i] !== exp_d) begin
                errors++;
                $display("FAIL b2b_rsp_data idx=%0d got %h required %h", i, rsp_q[i], exp_d);
            end
        end
    endtask

    task automatic test_hold_valid();
        bit ok;
        int base = wr_commits;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h20; req_wdata = 8'h11;
        wait_ready(ok);
        tick();
        for (int j = 1; j <= 3; j++) begin
            req_addr = AW'(8'h20 + j);
            req_wdata = DW'(8'h11 + j);
            tick();
            checks++;
            if (sram_addr !== 7'h20 || sram_wdata !== 8'h11) begin
                errors++;
                $display("FAIL hold_bus_stable step=%0d addr=%h data=%h required 20 11", j, sram_addr, sram_wdata);
            end
        end
        req_valid = 1'b0;
        wait_ready(ok);
        tick();
        checks++;
        if (wr_commits != base + 1 || last_waddr !== 7'h20 || last_wdata !== 8'h11) begin
            errors++;
            $display("FAIL hold_single_op commits=%0d addr=%h data=%h required 1 20 11",
                     wr_commits - base, last_waddr, last_wdata);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h05;
        wait_ready(ok);
        rsp_q.delete();
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if (sram_oe_n !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre_oe got %b required 0", sram_oe_n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111 ||
            rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release strobes=%b rsp_valid=%b ready=%b required 11111 0 0",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, rsp_valid, req_ready);
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got %b required 1", req_ready);
        end
        tick();
        tick();
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_no_rsp got %0d responses required 0", rsp_q.size());
        end
    endtask

    task automatic test_err();
`ifdef SRAM_WR_VERIFY_EN
        bit ok;
        rsp_q.delete();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h3F; req_wdata = 8'hFF;
        wait_ready(ok);
        tick();
        req_valid = 1'b0;
        wait_ready(ok);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL verify_err_set got %b required 1", err);
        end
        req_valid = 1'b1; req_addr = 7'h01; req_wdata = 8'h55;
        wait_ready(ok);
        tick();
        req_valid = 1'b0;
        wait_ready(ok);
        tick();
        checks++;
        if (err !== 1'b1 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL verify_err_sticky err=%b rsp=%0d required 1 0", err, rsp_q.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL verify_err_clear got %b required 0", err);
        end
        tick();
        rst = 1'b0;
        tick();
`else
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_tied got %b required 0", err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_hold_valid();
        test_reset_mid();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
